// File: rtl/line_sequencer.sv
`default_nettype none
// ============================================================================
// line_sequencer : bottling-line master sequencer (move, fill, inspect, eject)
// Revision 1.0
// ============================================================================
module line_sequencer #(
    parameter int unsigned TRAVEL_TIMEOUT = 2000,
    parameter int unsigned FILL_TIMEOUT   = 5000,
    parameter int unsigned QC_TIMEOUT     = 1000,
    parameter int unsigned EJECT_CYCLES   = 50,
    parameter int unsigned DOZEN          = 12
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       fault_clear,
    input  logic       bottle_present,
    input  logic       bottle_full,
    input  logic       qc_ok,
    input  logic       qc_bad,
    input  logic       reservoir_empty,
    output logic       motor,
    output logic       valve,
    output logic       eject,
    output logic       running,
    output logic       fault,
    output logic [1:0] fault_code,
    output logic [2:0] state,
    output logic [3:0] good_count,
    output logic       dozen_pulse
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MOVE    = 3'd1,
        FILL    = 3'd2,
        INSPECT = 3'd3,
        EJECT   = 3'd4,
        RELEASE = 3'd5,
        FAULT   = 3'd6
    } state_t;

    localparam logic [15:0] TRAVEL_LAST = 16'(TRAVEL_TIMEOUT - 1);
    localparam logic [15:0] FILL_LAST   = 16'(FILL_TIMEOUT - 1);
    localparam logic [15:0] QC_LAST     = 16'(QC_TIMEOUT - 1);
    localparam logic [15:0] EJECT_LAST  = 16'(EJECT_CYCLES - 1);
    localparam logic [3:0]  DOZEN_LAST  = 4'(DOZEN - 1);

    state_t      cur_state;
    state_t      next_state;
    logic [15:0] timer;
    logic        stop_pending;
    logic        clear_pending;
    logic        approve;
    logic [1:0]  next_code;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            cur_state <= IDLE;
        end else begin
            cur_state <= next_state;
        end
    end

    // Earlier branches win, so a normal event always beats a same-cycle timeout.
    always_comb begin
        next_state    = cur_state;
        next_code     = fault_code;
        clear_pending = 1'b0;
        approve       = 1'b0;
        case (cur_state)
            IDLE: begin
                if (start && !reservoir_empty) next_state = MOVE;
            end
            MOVE: begin
                if (stop_pending) begin
                    next_state    = IDLE;
                    clear_pending = 1'b1;
                end else if (bottle_present) begin
                    next_state = FILL;
                end else if (timer == TRAVEL_LAST) begin
                    next_state = FAULT;
                    next_code  = 2'b01;
                end
            end
            FILL: begin
                if (bottle_full) begin
                    next_state = INSPECT;
                end else if (reservoir_empty) begin
                    next_state = FAULT;
                    next_code  = 2'b10;
                end else if (timer == FILL_LAST) begin
                    next_state = FAULT;
                    next_code  = 2'b11;
                end
            end
            INSPECT: begin
                if (qc_bad) begin
                    next_state = EJECT;
                end else if (qc_ok) begin
                    next_state = RELEASE;
                    approve    = 1'b1;
                end else if (timer == QC_LAST) begin
                    next_state = EJECT;
                end
            end
            EJECT: begin
                if (timer == EJECT_LAST) next_state = RELEASE;
            end
            RELEASE: begin
                if (!bottle_present) begin
                    if (stop_pending) begin
                        next_state    = IDLE;
                        clear_pending = 1'b1;
                    end else begin
                        next_state = MOVE;
                    end
                end else if (timer == TRAVEL_LAST) begin
                    next_state = FAULT;
                    next_code  = 2'b01;
                end
            end
            FAULT: begin
                if (fault_clear) begin
                    next_state    = IDLE;
                    next_code     = 2'b00;
                    clear_pending = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            timer        <= 16'd0;
            stop_pending <= 1'b0;
            fault_code   <= 2'b00;
        end else begin
            timer      <= (next_state != cur_state) ? 16'd0 : timer + 16'd1;
            fault_code <= next_code;
            if (clear_pending) begin
                stop_pending <= 1'b0;
            end else if (stop && cur_state != IDLE && cur_state != FAULT) begin
                stop_pending <= 1'b1;
            end
        end
    end

    // Approved-bottle counter survives faults; only reset clears it.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            good_count  <= 4'd0;
            dozen_pulse <= 1'b0;
        end else begin
            dozen_pulse <= 1'b0;
            if (approve) begin
                if (good_count == DOZEN_LAST) begin
                    good_count  <= 4'd0;
                    dozen_pulse <= 1'b1;
                end else begin
                    good_count <= good_count + 4'd1;
                end
            end
        end
    end

    assign state   = cur_state;
    assign motor   = (cur_state == MOVE) || (cur_state == RELEASE);
    assign valve   = (cur_state == FILL);
    assign eject   = (cur_state == EJECT);
    assign running = (cur_state != IDLE) && (cur_state != FAULT);
    assign fault   = (cur_state == FAULT);

endmodule
`default_nettype wire

// File: tb/tb_line_sequencer.sv
`default_nettype none
// ============================================================================
// tb_line_sequencer : scoreboard bench, one expected record per state change
// Revision 1.0
// ============================================================================
module tb_line_sequencer;

    localparam logic [2:0] S_IDLE = 3'd0, S_MOVE = 3'd1, S_FILL = 3'd2, S_INSP = 3'd3,
                           S_EJECT = 3'd4, S_REL = 3'd5, S_FAULT = 3'd6;

    logic clk = 1'b0;
    logic reset, start, stop, fault_clear, bottle_present, bottle_full;
    logic qc_ok, qc_bad, reservoir_empty;
    logic motor, valve, eject, running, fault, dozen_pulse;
    logic [1:0] fault_code;
    logic [2:0] state;
    logic [3:0] good_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [13:0] v;
        int          dwell;
    } ev_t;

    ev_t        exp_q[$];
    int         pulse_pending = 0;
    logic [3:0] good_exp = 4'd0;

    line_sequencer #(
        .TRAVEL_TIMEOUT(8),
        .FILL_TIMEOUT  (10),
        .QC_TIMEOUT    (6),
        .EJECT_CYCLES  (3),
        .DOZEN         (12)
    ) dut (
        .CLK            (clk),
        .reset          (reset),
        .start          (start),
        .stop           (stop),
        .fault_clear    (fault_clear),
        .bottle_present (bottle_present),
        .bottle_full    (bottle_full),
        .qc_ok          (qc_ok),
        .qc_bad         (qc_bad),
        .reservoir_empty(reservoir_empty),
        .motor          (motor),
        .valve          (valve),
        .eject          (eject),
        .running        (running),
        .fault          (fault),
        .fault_code     (fault_code),
        .state          (state),
        .good_count     (good_count),
        .dozen_pulse    (dozen_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Record layout: state, motor, valve, eject, running, fault, fault_code, good_count
    function automatic logic [13:0] pack_exp(input logic [2:0] st, input logic [1:0] code,
                                             input logic [3:0] g);
        logic m, v, e, r, f;
        m = (st == S_MOVE) || (st == S_REL);
        v = (st == S_FILL);
        e = (st == S_EJECT);
        r = (st != S_IDLE) && (st != S_FAULT);
        f = (st == S_FAULT);
        return {st, m, v, e, r, f, code, g};
    endfunction

    task automatic ev(input logic [2:0] st, input int dw, input logic [1:0] code);
        ev_t e;
        e.v     = pack_exp(st, code, good_exp);
        e.dwell = dw;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every observed state change pops one expected record.
    initial begin
        logic [2:0] prev_state;
        int         dwell;
        ev_t        e;
        prev_state = S_IDLE;
        dwell      = 0;
        forever begin
            @(negedge clk);
            if (!$isunknown(state)) begin
                if (state != prev_state) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_transition actual_state=%0d from=%0d", state, prev_state);
                    end else begin
                        e = exp_q.pop_front();
                        check("transition", int'({state, motor, valve, eject, running, fault,
                                                  fault_code, good_count}), int'(e.v));
                        if (e.dwell != 0) check("dwell", dwell, e.dwell);
                    end
                    dwell      = 1;
                    prev_state = state;
                end else begin
                    dwell++;
                end
                if (dozen_pulse === 1'b1) begin
                    if (pulse_pending > 0) begin
                        pulse_pending--;
                        check("dozen_wrap_count", int'(good_count), 0);
                    end else begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_dozen_pulse actual=1 expected=0");
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; fault_clear = 1'b0;
        bottle_present = 1'b0; bottle_full = 1'b0; qc_ok = 1'b0; qc_bad = 1'b0;
        reservoir_empty = 1'b0;
        cyc(3);
        check("reset_state", int'(state), 0);
        check("reset_outputs", int'({motor, valve, eject, running, fault, dozen_pulse}), 0);
        check("reset_code", int'(fault_code), 0);
        check("reset_good", int'(good_count), 0);
        reset = 1'b0;
        cyc(1);

        // start is ignored while the reservoir is empty
        reservoir_empty = 1'b1; start = 1'b1; cyc(1); start = 1'b0; reservoir_empty = 1'b0;
        cyc(1);
        check("start_blocked_by_reservoir", int'(state), 0);

        // Happy path, then stop requested while moving
        ev(S_MOVE, 0, 2'b00); start = 1'b1; cyc(1); start = 1'b0;
        cyc(2); ev(S_FILL, 3, 2'b00); bottle_present = 1'b1; cyc(1);
        cyc(4); ev(S_INSP, 5, 2'b00); bottle_full = 1'b1; cyc(1); bottle_full = 1'b0;
        good_exp = 4'd1; ev(S_REL, 1, 2'b00); qc_ok = 1'b1; cyc(1); qc_ok = 1'b0;
        ev(S_MOVE, 1, 2'b00); bottle_present = 1'b0; cyc(1);
        stop = 1'b1; cyc(1); stop = 1'b0;
        ev(S_IDLE, 2, 2'b00); cyc(1);

        // Reject on qc_ok&qc_bad, then QC timeout, then stop in RELEASE
        ev(S_MOVE, 0, 2'b00); start = 1'b1; cyc(1); start = 1'b0;
        ev(S_FILL, 1, 2'b00); bottle_present = 1'b1; cyc(1);
        ev(S_INSP, 1, 2'b00); bottle_full = 1'b1; cyc(1); bottle_full = 1'b0;
        ev(S_EJECT, 1, 2'b00); qc_ok = 1'b1; qc_bad = 1'b1; cyc(1); qc_ok = 1'b0; qc_bad = 1'b0;
        ev(S_REL, 3, 2'b00); cyc(3);
        ev(S_MOVE, 1, 2'b00); bottle_present = 1'b0; cyc(1);
        ev(S_FILL, 1, 2'b00); bottle_present = 1'b1; cyc(1);
        ev(S_INSP, 1, 2'b00); bottle_full = 1'b1; cyc(1); bottle_full = 1'b0;
        ev(S_EJECT, 6, 2'b00); cyc(6);
        ev(S_REL, 3, 2'b00); cyc(3);
        stop = 1'b1; cyc(1); stop = 1'b0;
        ev(S_IDLE, 2, 2'b00); bottle_present = 1'b0; cyc(1);

        // No bottle: conveyor timeout, start ignored in FAULT, then clear
        ev(S_MOVE, 0, 2'b00); start = 1'b1; cyc(1); start = 1'b0;
        ev(S_FAULT, 8, 2'b01); cyc(8);
        start = 1'b1; cyc(1); start = 1'b0; cyc(1);
        ev(S_IDLE, 3, 2'b00); fault_clear = 1'b1; cyc(1); fault_clear = 1'b0;

        // Reservoir empties during FILL; then same cycle as bottle_full
        ev(S_MOVE, 0, 2'b00); start = 1'b1; cyc(1); start = 1'b0;
        ev(S_FILL, 1, 2'b00); bottle_present = 1'b1; cyc(1);
        cyc(2); ev(S_FAULT, 3, 2'b10); reservoir_empty = 1'b1; cyc(1); reservoir_empty = 1'b0;
        ev(S_IDLE, 1, 2'b00); fault_clear = 1'b1; cyc(1); fault_clear = 1'b0;
        ev(S_MOVE, 0, 2'b00); start = 1'b1; cyc(1); start = 1'b0;
        ev(S_FILL, 1, 2'b00); cyc(1);
        ev(S_INSP, 1, 2'b00); reservoir_empty = 1'b1; bottle_full = 1'b1; cyc(1);
        reservoir_empty = 1'b0; bottle_full = 1'b0;
        ev(S_EJECT, 1, 2'b00); qc_bad = 1'b1; cyc(1); qc_bad = 1'b0;
        ev(S_REL, 3, 2'b00); cyc(3);
        stop = 1'b1; cyc(1); stop = 1'b0;
        ev(S_IDLE, 2, 2'b00); bottle_present = 1'b0; cyc(1);

        // Fill overtime
        ev(S_MOVE, 0, 2'b00); start = 1'b1; cyc(1); start = 1'b0;
        ev(S_FILL, 1, 2'b00); bottle_present = 1'b1; cyc(1);
        ev(S_FAULT, 10, 2'b11); cyc(10);
        ev(S_IDLE, 1, 2'b00); fault_clear = 1'b1; cyc(1); fault_clear = 1'b0;

        // Bottle never leaves in RELEASE: conveyor timeout, count kept
        ev(S_MOVE, 0, 2'b00); start = 1'b1; cyc(1); start = 1'b0;
        ev(S_FILL, 1, 2'b00); cyc(1);
        ev(S_INSP, 1, 2'b00); bottle_full = 1'b1; cyc(1); bottle_full = 1'b0;
        good_exp = 4'd2; ev(S_REL, 1, 2'b00); qc_ok = 1'b1; cyc(1); qc_ok = 1'b0;
        ev(S_FAULT, 8, 2'b01); cyc(8);
        ev(S_IDLE, 1, 2'b00); fault_clear = 1'b1; cyc(1); fault_clear = 1'b0;

        // Asynchronous reset in the middle of FILL
        ev(S_MOVE, 0, 2'b00); start = 1'b1; cyc(1); start = 1'b0;
        ev(S_FILL, 1, 2'b00); cyc(1);
        cyc(1);
        good_exp = 4'd0; ev(S_IDLE, 0, 2'b00);
        #2 reset = 1'b1;
        #1;
        check("async_reset_valve", int'(valve), 0);
        check("async_reset_state", int'(state), 0);
        @(posedge clk); #1;
        reset = 1'b0; bottle_present = 1'b0;
        cyc(1);

        // Twelve approvals wrap the dozen counter; stop during the last FILL
        ev(S_MOVE, 0, 2'b00); start = 1'b1; cyc(1); start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            ev(S_FILL, 1, 2'b00); bottle_present = 1'b1; cyc(1);
            ev(S_INSP, 1, 2'b00); bottle_full = 1'b1;
            if (i == 11) stop = 1'b1;
            cyc(1); bottle_full = 1'b0; stop = 1'b0;
            if (good_exp == 4'd11) begin
                good_exp = 4'd0;
                pulse_pending++;
            end else begin
                good_exp = good_exp + 4'd1;
            end
            ev(S_REL, 1, 2'b00); qc_ok = 1'b1; cyc(1); qc_ok = 1'b0;
            ev((i == 11) ? S_IDLE : S_MOVE, 1, 2'b00); bottle_present = 1'b0; cyc(1);
        end

        cyc(3);
        check("events_outstanding", exp_q.size(), 0);
        check("dozen_pulses_outstanding", pulse_pending, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
